// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: WB-stage request, LU result port and register-file port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's.
// Optional WB_ARB_PERF_EN adds the StallCnt / LuWaitCnt performance counters.
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              RegWriteW;
  logic [4:0]        WriteRegW;
  logic [DATA_W-1:0] ResultW;
  logic              LuValid;
  logic [4:0]        LuReg;
  logic [DATA_W-1:0] LuData;
  logic              LuReady;
  logic              RegWriteRF;
  logic [4:0]        WriteRegRF;
  logic [DATA_W-1:0] WriteDataRF;
  logic              StallReq;
  logic [CntW-1:0]   BufCount;
`ifdef WB_ARB_PERF_EN
  logic [31:0]       StallCnt;
  logic [31:0]       LuWaitCnt;

  modport slave (
    input  RegWriteW, WriteRegW, ResultW, LuValid, LuReg, LuData,
    output LuReady, RegWriteRF, WriteRegRF, WriteDataRF, StallReq, BufCount,
    output StallCnt, LuWaitCnt
  );

  modport master (
    output RegWriteW, WriteRegW, ResultW, LuValid, LuReg, LuData,
    input  LuReady, RegWriteRF, WriteRegRF, WriteDataRF, StallReq, BufCount,
    input  StallCnt, LuWaitCnt
  );
`else
  modport slave (
    input  RegWriteW, WriteRegW, ResultW, LuValid, LuReg, LuData,
    output LuReady, RegWriteRF, WriteRegRF, WriteDataRF, StallReq, BufCount
  );

  modport master (
    output RegWriteW, WriteRegW, ResultW, LuValid, LuReg, LuData,
    input  LuReady, RegWriteRF, WriteRegRF, WriteDataRF, StallReq, BufCount
  );
`endif
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and a long-latency unit.
// LU results queue in a small FIFO and drain on idle WB cycles; if the FIFO head is blocked
// for MAX_WAIT cycles a one-cycle pipeline stall (STEAL) is forced to retire it.
// Optional feature macro: WB_ARB_PERF_EN (StallCnt / LuWaitCnt saturating counters).
module wb_port_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic              CLK,
  input logic              RST,
  wb_port_arbiter_if.slave io_bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AgeW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [AgeW-1:0] AgeLast = AgeW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StSteal} state_e;

  state_e            r_state_q, w_state_d;
  logic [AgeW-1:0]   r_age_q, w_age_d;
  logic [PtrW-1:0]   r_wptr_q, r_rptr_q;
  logic [CntW-1:0]   r_count_q, w_count_d;
  logic              r_lu_ready_q;
  logic [4:0]        r_lu_reg_q  [DEPTH];
  logic [DATA_W-1:0] r_lu_data_q [DEPTH];

  logic              w_empty, w_push, w_store, w_sel_lu, w_pop, w_blocked;
  logic              w_rf_we;
  logic [4:0]        w_rf_reg;
  logic [DATA_W-1:0] w_rf_data;

  assign w_empty   = (r_count_q == '0);
  assign w_push    = io_bus.LuValid && r_lu_ready_q;
  // Register 0 results complete the handshake but are never written.
  assign w_store   = w_push && (io_bus.LuReg != 5'd0);
  // During STEAL the WB request is ignored; the frozen WB register re-presents it later.
  assign w_sel_lu  = (r_state_q == StSteal) || (!io_bus.RegWriteW && !w_empty);
  assign w_pop     = w_sel_lu;
  assign w_blocked = (r_state_q == StWait) && io_bus.RegWriteW;
  assign w_count_d = r_count_q + CntW'(w_store) - CntW'(w_pop);

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr_q     <= '0;
      r_rptr_q     <= '0;
      r_count_q    <= '0;
      r_lu_ready_q <= 1'b0;
    end else begin
      if (w_store) r_wptr_q <= r_wptr_q + PtrW'(1);
      if (w_pop)   r_rptr_q <= r_rptr_q + PtrW'(1);
      r_count_q    <= w_count_d;
      r_lu_ready_q <= (w_count_d != CntW'(DEPTH));
    end
  end

  // FIFO storage; contents are only observable through valid pointers, so no reset
  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_lu_reg_q[r_wptr_q]  <= io_bus.LuReg;
      r_lu_data_q[r_wptr_q] <= io_bus.LuData;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state_q <= StIdle;
    else      r_state_q <= w_state_d;
  end

  // FSM next-state logic
  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StIdle: begin
        if (w_store) w_state_d = StWait;
      end
      StWait: begin
        if (w_blocked && (r_age_q == AgeLast)) w_state_d = StSteal;
        else if (w_pop && (w_count_d == '0))   w_state_d = StIdle;
      end
      StSteal: begin
        w_state_d = (w_count_d != '0) ? StWait : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Head age: counts blocked cycles in WAIT, cleared on any pop or when a steal is scheduled
  always_comb begin
    w_age_d = '0;
    if ((r_state_q == StWait) && !w_pop && w_blocked && (r_age_q != AgeLast)) begin
      w_age_d = r_age_q + AgeW'(1);
    end
  end

  // Age register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_age_q <= '0;
    else      r_age_q <= w_age_d;
  end

  // FSM / port-select outputs; forced quiet while reset is asserted
  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_reg  = '0;
    w_rf_data = '0;
    if (RST) begin
      if (w_sel_lu) begin
        w_rf_we   = 1'b1;
        w_rf_reg  = r_lu_reg_q[r_rptr_q];
        w_rf_data = r_lu_data_q[r_rptr_q];
      end else if (io_bus.RegWriteW) begin
        w_rf_we   = 1'b1;
        w_rf_reg  = io_bus.WriteRegW;
        w_rf_data = io_bus.ResultW;
      end
    end
  end

  assign io_bus.RegWriteRF  = w_rf_we;
  assign io_bus.WriteRegRF  = w_rf_reg;
  assign io_bus.WriteDataRF = w_rf_data;
  assign io_bus.StallReq    = (r_state_q == StSteal);
  assign io_bus.LuReady     = r_lu_ready_q;
  assign io_bus.BufCount    = r_count_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_stall_cnt_q, r_wait_cnt_q;

  // Saturating counters of STEAL cycles and of cycles the FIFO head was blocked
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stall_cnt_q <= '0;
      r_wait_cnt_q  <= '0;
    end else begin
      if ((r_state_q == StSteal) && (r_stall_cnt_q != '1)) r_stall_cnt_q <= r_stall_cnt_q + 32'd1;
      if (w_blocked && (r_wait_cnt_q != '1))               r_wait_cnt_q  <= r_wait_cnt_q + 32'd1;
    end
  end

  assign io_bus.StallCnt  = r_stall_cnt_q;
  assign io_bus.LuWaitCnt = r_wait_cnt_q;
`endif
endmodule
